// File: rtl/ray_march_ctrl.sv
// Sphere-tracing control FSM. It marches one ray through a scene distance
// oracle in signed Q8.24 fixed point, with at most one query in flight.
module ray_march_ctrl #(
  parameter int unsigned        MAX_STEPS = 64,
  parameter logic signed [31:0] EPSILON   = 32'sh00028F5C,
  parameter logic signed [31:0] T_MAX     = 32'sh14000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [95:0]        ray_origin,
  input  logic [95:0]        ray_dir,
  input  logic [2:0]         obj_sel_in,
  output logic               q_valid,
  output logic [95:0]        q_pos,
  output logic [2:0]         q_obj_sel,
  input  logic signed [31:0] q_dist,
  input  logic               q_dist_valid,
  output logic               done,
  output logic               hit,
  output logic signed [31:0] hit_t,
  output logic [95:0]        hit_pos,
  output logic [7:0]         steps
);

  typedef enum logic [2:0] {IDLE, POS, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] MAX_STEPS_W = 8'(MAX_STEPS);

  // Q8.24 x Q8.24 product truncated back to Q8.24 (bits [55:24]).
  function automatic logic signed [31:0] fx_mul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
    logic [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return p[55:24];
  endfunction

  state_t             state_q, state_d;
  logic [95:0]        origin_q, origin_d;
  logic [95:0]        dir_q, dir_d;
  logic [2:0]         sel_q, sel_d;
  logic signed [31:0] t_q, t_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [95:0]        pos_q, pos_d;
  logic               hit_q, hit_d;
  logic signed [31:0] hit_t_q, hit_t_d;
  logic [95:0]        hit_pos_q, hit_pos_d;
  logic [7:0]         steps_q, steps_d;

  logic signed [31:0] t_next;
  logic [7:0]         cnt_inc;

  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    dir_d     = dir_q;
    sel_d     = sel_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    hit_d     = hit_q;
    hit_t_d   = hit_t_q;
    hit_pos_d = hit_pos_q;
    steps_d   = steps_q;
    t_next    = t_q + q_dist;
    cnt_inc   = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          origin_d = ray_origin;
          dir_d    = ray_dir;
          sel_d    = obj_sel_in;
          t_d      = '0;
          cnt_d    = '0;
          state_d  = POS;
        end
      end
      POS: begin
        for (int i = 0; i < 3; i++) begin
          pos_d[32*i +: 32] = origin_q[32*i +: 32] + fx_mul(t_q, dir_q[32*i +: 32]);
        end
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (q_dist_valid) begin
          cnt_d = cnt_inc;
          // A hit wins over the far-plane and step-limit exits.
          if (q_dist < EPSILON) begin
            hit_d     = 1'b1;
            hit_t_d   = t_q;
            hit_pos_d = pos_q;
            steps_d   = cnt_inc;
            state_d   = DONE;
          end else if (t_next >= T_MAX || cnt_inc == MAX_STEPS_W) begin
            hit_d     = 1'b0;
            hit_t_d   = t_next;
            hit_pos_d = pos_q;
            steps_d   = cnt_inc;
            state_d   = DONE;
          end else begin
            t_d     = t_next;
            state_d = POS;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      origin_q  <= '0;
      dir_q     <= '0;
      sel_q     <= '0;
      t_q       <= '0;
      cnt_q     <= '0;
      pos_q     <= '0;
      hit_q     <= 1'b0;
      hit_t_q   <= '0;
      hit_pos_q <= '0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      origin_q  <= origin_d;
      dir_q     <= dir_d;
      sel_q     <= sel_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      hit_q     <= hit_d;
      hit_t_q   <= hit_t_d;
      hit_pos_q <= hit_pos_d;
      steps_q   <= steps_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign q_valid   = (state_q == ISSUE);
  assign done      = (state_q == DONE);
  assign q_pos     = pos_q;
  assign q_obj_sel = sel_q;
  assign hit       = hit_q;
  assign hit_t     = hit_t_q;
  assign hit_pos   = hit_pos_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Directed bench for ray_march_ctrl: table of rays against a bench-side
// scene responder, plus reset-in-flight and spurious-strobe sequences.
module tb_ray_march_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [95:0] ray_origin;
  logic [95:0] ray_dir;
  logic [2:0]  obj_sel_in;
  logic        q_valid;
  logic [95:0] q_pos;
  logic [2:0]  q_obj_sel;
  logic [31:0] q_dist;
  logic        q_dist_valid;
  logic        done;
  logic        hit;
  logic [31:0] hit_t;
  logic [95:0] hit_pos;
  logic [7:0]  steps;

  int n_chk  = 0;
  int n_pass = 0;

  ray_march_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .obj_sel_in(obj_sel_in),
    .q_valid(q_valid), .q_pos(q_pos), .q_obj_sel(q_obj_sel),
    .q_dist(q_dist), .q_dist_valid(q_dist_valid),
    .done(done), .hit(hit), .hit_t(hit_t), .hit_pos(hit_pos), .steps(steps)
  );

  always #5 clk = ~clk;

  // mode 0: constant distance cd; mode 1: unit sphere at origin (ray on z axis)
  typedef struct {
    string       name;
    logic [95:0] org;
    logic [95:0] dir;
    int          mode;
    logic [31:0] cd;
    int          lat;
    bit          noise;
    logic [2:0]  sel;
    logic        exp_hit;
    logic [31:0] exp_t;
    logic [7:0]  exp_steps;
    logic [95:0] exp_pos;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [31:0] model(input vec_t v, input logic [95:0] p);
    logic signed [31:0] z;
    z = p[95:64];
    if (v.mode == 1) return ((z < 0) ? -z : z) - 32'h01000000;
    return v.cd;
  endfunction

  task automatic run_ray(input vec_t v);
    int cyc, nq, lat_first, pend;
    logic [31:0] d;
    bit inj, fin;
    @(negedge clk);
    if (v.noise) begin
      q_dist = 32'hFF000000;
      q_dist_valid = 1'b1;
      @(negedge clk);
      q_dist_valid = 1'b0;
    end
    ray_origin = v.org;
    ray_dir    = v.dir;
    obj_sel_in = v.sel;
    start      = 1'b1;
    cyc = 0; nq = 0; lat_first = -1; pend = -1; inj = 0; fin = 0; d = '0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      q_dist_valid = 1'b0;
      if (inj) begin
        start = 1'b1;
        ray_origin = '1;
        inj = 0;
      end
      if (done) fin = 1;
      else begin
        if (pend == 0) begin
          q_dist = d;
          q_dist_valid = 1'b1;
          pend = -1;
        end else if (pend > 0) pend--;
        if (q_valid) begin
          nq++;
          if (nq == 1) begin
            lat_first = cyc;
            inj = v.noise;
          end
          d = model(v, q_pos);
          pend = v.lat - 1;
        end
      end
    end
    chk({v.name, " done_seen"}, 96'(fin), 96'd1);
    chk({v.name, " q_valid_latency"}, 96'(lat_first), 96'd2);
    chk({v.name, " hit"}, 96'(hit), 96'(v.exp_hit));
    chk({v.name, " hit_t"}, 96'(hit_t), 96'(v.exp_t));
    chk({v.name, " steps"}, 96'(steps), 96'(v.exp_steps));
    chk({v.name, " hit_pos"}, hit_pos, v.exp_pos);
    chk({v.name, " query_count"}, 96'(nq), 96'(v.exp_steps));
    chk({v.name, " q_obj_sel"}, 96'(q_obj_sel), 96'(v.sel));
    @(negedge clk);
    chk({v.name, " done_one_cycle"}, 96'(done), 96'd0);
    chk({v.name, " ready_after_done"}, 96'(ready), 96'd1);
  endtask

  initial begin
    vec_t sph;
    bit   saw_done, timed_out;
    int   w;

    vecs[0] = '{"sphere", {32'hFD000000, 32'h0, 32'h0}, {32'h01000000, 32'h0, 32'h0},
                1, 32'h0, 3, 1'b0, 3'd5, 1'b1, 32'h02000000, 8'd2,
                {32'hFF000000, 32'h0, 32'h0}};
    vecs[1] = '{"sphere_noise", {32'hFD000000, 32'h0, 32'h0}, {32'h01000000, 32'h0, 32'h0},
                1, 32'h0, 3, 1'b1, 3'd2, 1'b1, 32'h02000000, 8'd2,
                {32'hFF000000, 32'h0, 32'h0}};
    vecs[2] = '{"far_plane", {32'hFD000000, 32'h0, 32'h01000000}, {32'hFF000000, 32'h0, 32'h0},
                0, 32'h00800000, 1, 1'b0, 3'd1, 1'b0, 32'h14000000, 8'd40,
                {32'hE9800000, 32'h0, 32'h01000000}};
    vecs[3] = '{"max_steps", 96'h0, {32'h01000000, 32'h0, 32'h0},
                0, 32'h00100000, 2, 1'b0, 3'd7, 1'b0, 32'h04000000, 8'd64,
                {32'h03F00000, 32'h0, 32'h0}};
    vecs[4] = '{"neg_dist", {32'hFD000000, 32'h02000000, 32'h01000000}, {32'hFF000000, 32'h0, 32'h0},
                0, 32'hFF000000, 1, 1'b0, 3'd3, 1'b1, 32'h0, 8'd1,
                {32'hFD000000, 32'h02000000, 32'h01000000}};
    vecs[5] = '{"eps_exact", 96'h0, {32'h01000000, 32'h0, 32'h0},
                0, 32'h00028F5C, 1, 1'b0, 3'd4, 1'b0, 32'h00A3D700, 8'd64,
                {32'h00A147A4, 32'h0, 32'h0}};

    rst = 1'b1; start = 1'b0; q_dist_valid = 1'b0; q_dist = '0;
    ray_origin = '0; ray_dir = '0; obj_sel_in = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 96'(ready), 96'd1);
    chk("reset q_valid", 96'(q_valid), 96'd0);
    chk("reset done", 96'(done), 96'd0);
    chk("reset hit", 96'(hit), 96'd0);
    chk("reset hit_t", 96'(hit_t), 96'd0);
    chk("reset steps", 96'(steps), 96'd0);
    chk("reset q_pos", q_pos, 96'd0);
    chk("reset hit_pos", hit_pos, 96'd0);
    chk("reset q_obj_sel", 96'(q_obj_sel), 96'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_ray(vecs[i]);

    // Reset while a query is outstanding, then a stale response arrives.
    @(negedge clk);
    ray_origin = vecs[0].org; ray_dir = vecs[0].dir; obj_sel_in = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1;
    for (int c = 0; c < 10; c++) begin
      if (q_valid) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
    chk("rst_wait q_valid_seen", 96'(timed_out), 96'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait ready", 96'(ready), 96'd1);
    chk("rst_wait q_valid", 96'(q_valid), 96'd0);
    chk("rst_wait hit_t", 96'(hit_t), 96'd0);
    chk("rst_wait steps", 96'(steps), 96'd0);
    chk("rst_wait q_pos", q_pos, 96'd0);
    chk("rst_wait hit_pos", hit_pos, 96'd0);
    chk("rst_wait q_obj_sel", 96'(q_obj_sel), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q_dist = 32'hFF000000;
    q_dist_valid = 1'b1;
    @(negedge clk);
    q_dist_valid = 1'b0;
    saw_done = 0;
    w = 0;
    while (w < 6) begin
      if (done || !ready) saw_done = 1;
      @(negedge clk);
      w++;
    end
    chk("stale_resp no_done_or_busy", 96'(saw_done), 96'd0);
    chk("stale_resp hit", 96'(hit), 96'd0);
    chk("stale_resp steps", 96'(steps), 96'd0);

    sph = vecs[0];
    sph.name = "post_reset_sphere";
    run_ray(sph);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
